// File: rtl/fht_stage_ctrl_pkg.sv
// Shared FHT stage-controller definitions: FSM state encodings and stage-count derivation.
package fht_stage_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Index of the final stage; a transform runs stages 0..fht_last(a_bit).
    function automatic int unsigned fht_last(input int unsigned a_bit);
        return a_bit + 1;
    endfunction

endpackage

// File: rtl/fht_delay_line.sv
// Fixed-depth shift register used to align write-back address and strobe with the datapath.
module fht_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [WIDTH-1:0] iDATA,
    output logic [WIDTH-1:0] oDATA
);

    localparam int unsigned TOTAL = WIDTH * DEPTH;

    logic [TOTAL-1:0] r_pipe;
    logic [TOTAL-1:0] w_pipe_nxt;

    if (DEPTH == 1) begin : g_single
        assign w_pipe_nxt = iDATA;
    end else begin : g_multi
        assign w_pipe_nxt = {r_pipe[TOTAL-WIDTH-1:0], iDATA};
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= w_pipe_nxt;
        end
    end

    assign oDATA = r_pipe[TOTAL-1 -: WIDTH];

endmodule

// File: rtl/fht_stage_ctrl.sv
// FHT stage controller: sequences per-stage bank reads, twiddle addressing and delayed write-back.
module fht_stage_ctrl
    import fht_stage_ctrl_pkg::*;
#(
    parameter int unsigned A_BIT    = 8,
    parameter int unsigned SEC_BIT  = 4,
    parameter int unsigned PIPE_LAT = 4
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iSTART,
    output logic               oBUSY,
    output logic               oDONE,
    output logic [A_BIT-1:0]   oRD_ADDR_0,
    output logic [A_BIT-1:0]   oRD_ADDR_1,
    output logic [A_BIT-1:0]   oRD_ADDR_2,
    output logic [A_BIT-1:0]   oRD_ADDR_3,
    output logic [A_BIT-1:0]   oROM_ADDR,
    output logic [A_BIT-1:0]   oWR_ADDR,
    output logic               oWE,
    output logic               oST_ZERO,
    output logic               oST_LAST,
    output logic               o2ND_PART_SUBSEC,
    output logic [SEC_BIT-1:0] oSECTOR
);

    localparam logic [SEC_BIT-1:0] LAST     = SEC_BIT'(fht_last(A_BIT));
    localparam int unsigned        DRN_BIT  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRN_BIT-1:0] DRN_END  = DRN_BIT'(PIPE_LAT - 1);
    localparam logic [A_BIT-1:0]   ADDR_ONE = {{(A_BIT-1){1'b0}}, 1'b1};
    localparam logic [SEC_BIT-1:0] SEC_ONE  = {{(SEC_BIT-1){1'b0}}, 1'b1};
    localparam logic [SEC_BIT-1:0] SEC_TWO  = SEC_BIT'(2);

    logic [1:0]         r_state;
    logic [SEC_BIT-1:0] r_s;
    logic [A_BIT-1:0]   r_cnt;
    logic               r_phase;
    logic [DRN_BIT-1:0] r_drn;

    logic [1:0]         w_state_nxt;
    logic [SEC_BIT-1:0] w_s_nxt;
    logic [A_BIT-1:0]   w_cnt_nxt;
    logic               w_phase_nxt;
    logic [DRN_BIT-1:0] w_drn_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_drn_nxt   = r_drn;
        case (r_state)
            ST_IDLE: begin
                if (iSTART) begin
                    w_state_nxt = ST_READ;
                    w_s_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_phase_nxt = 1'b0;
                end
            end
            ST_READ: begin
                w_phase_nxt = ~r_phase;
                if (r_phase) begin
                    w_cnt_nxt = r_cnt + ADDR_ONE;
                    if (r_cnt == '1) begin
                        w_state_nxt = ST_DRAIN;
                        w_drn_nxt   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                w_drn_nxt = r_drn + DRN_BIT'(1);
                // Last write of the stage lands in this final drain cycle.
                if (r_drn == DRN_END) begin
                    if (r_s == LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_READ;
                        w_s_nxt     = r_s + SEC_ONE;
                        w_cnt_nxt   = '0;
                        w_phase_nxt = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_drn   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
            r_drn   <= w_drn_nxt;
        end
    end

    logic               w_read;
    logic               w_busy;
    logic               w_hi_stage;
    logic [A_BIT-1:0]   w_mask;
    logic [A_BIT-1:0]   w_rom;
    logic [A_BIT-1:0]   w_partner;
    logic               w_wr_stb;
    logic [A_BIT:0]     w_dl_in;
    logic [A_BIT:0]     w_dl_out;
    logic               w_we;
    logic [A_BIT-1:0]   w_wr_addr;

    assign w_read     = (r_state == ST_READ);
    assign w_busy     = w_read | (r_state == ST_DRAIN);
    assign w_hi_stage = (r_s >= SEC_TWO);
    // Stage s>=2 pairs addresses differing in bit s-2; the mask is also the swap-select bit.
    assign w_mask     = ADDR_ONE << (r_s - SEC_TWO);
    assign w_rom      = r_cnt << (A_BIT + 1 - 32'(r_s));
    assign w_partner  = w_hi_stage ? (r_cnt ^ w_mask) : r_cnt;

    assign w_wr_stb = w_read & r_phase;
    assign w_dl_in  = {w_wr_stb, (w_wr_stb ? r_cnt : {A_BIT{1'b0}})};

    fht_delay_line #(
        .WIDTH (A_BIT + 1),
        .DEPTH (PIPE_LAT)
    ) u_wr_delay (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iDATA  (w_dl_in),
        .oDATA  (w_dl_out)
    );

    assign w_we      = w_dl_out[A_BIT];
    assign w_wr_addr = w_dl_out[A_BIT-1:0];

    assign oBUSY            = w_busy;
    assign oDONE            = (r_state == ST_DONE);
    assign oRD_ADDR_0       = w_read ? r_cnt : '0;
    assign oRD_ADDR_1       = w_read ? r_cnt : '0;
    assign oRD_ADDR_2       = w_read ? w_partner : '0;
    assign oRD_ADDR_3       = w_read ? w_partner : '0;
    assign oROM_ADDR        = (w_read && w_hi_stage) ? w_rom : '0;
    assign oWE              = w_we;
    assign oWR_ADDR         = w_wr_addr;
    assign o2ND_PART_SUBSEC = w_we & w_hi_stage & (|(w_wr_addr & w_mask));
    assign oST_ZERO         = w_busy & (r_s == '0);
    assign oST_LAST         = w_busy & (r_s == LAST);
    assign oSECTOR          = w_busy ? r_s : '0;

endmodule

// File: tb/tb_fht_stage_ctrl.sv
// Scoreboard bench for fht_stage_ctrl (A_BIT=3, PIPE_LAT=4): per-cycle expected outputs queued at start.
module tb_fht_stage_ctrl;

    localparam int unsigned A_BIT     = 3;
    localparam int unsigned SEC_BIT   = 4;
    localparam int unsigned PIPE_LAT  = 4;
    localparam int          STAGES    = 5;
    localparam int          STAGE_CYC = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done, we, st_zero, st_last, subsec;
    logic [2:0] rd0, rd1, rd2, rd3, rom, wr_addr;
    logic [3:0] sector;

    fht_stage_ctrl #(
        .A_BIT    (A_BIT),
        .SEC_BIT  (SEC_BIT),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .iCLK             (clk),
        .iRESET           (rst_n),
        .iSTART           (start),
        .oBUSY            (busy),
        .oDONE            (done),
        .oRD_ADDR_0       (rd0),
        .oRD_ADDR_1       (rd1),
        .oRD_ADDR_2       (rd2),
        .oRD_ADDR_3       (rd3),
        .oROM_ADDR        (rom),
        .oWR_ADDR         (wr_addr),
        .oWE              (we),
        .oST_ZERO         (st_zero),
        .oST_LAST         (st_last),
        .o2ND_PART_SUBSEC (subsec),
        .oSECTOR          (sector)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] rd0, rd1, rd2, rd3, rom, wr;
        logic       we, zero, last, subsec, busy, done;
        logic [3:0] sector;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   we_cnt = 0;
    int   last_we_cyc = -1;
    int   prev_sec = -1;
    int   stage3_rd2 [8] = '{2, 3, 0, 1, 6, 7, 4, 5};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.rd0 = rd0; o.rd1 = rd1; o.rd2 = rd2; o.rd3 = rd3;
        o.rom = rom; o.wr = wr_addr; o.we = we; o.zero = st_zero;
        o.last = st_last; o.subsec = subsec; o.busy = busy; o.done = done;
        o.sector = sector;
        return o;
    endfunction

    // Hand-derived timeline: 16 READ cycles then 4 DRAIN cycles per stage; writes at j=5,7,..,19.
    task automatic push_run(input int c0);
        exp_t e;
        int   cnt;
        int   wr;
        for (int s = 0; s < STAGES; s++) begin
            for (int j = 0; j < STAGE_CYC; j++) begin
                e.cyc      = c0 + 1 + s * STAGE_CYC + j;
                e.o        = '0;
                e.o.busy   = 1'b1;
                e.o.sector = 4'(s);
                e.o.zero   = (s == 0);
                e.o.last   = (s == STAGES - 1);
                if (j < 16) begin
                    cnt = j / 2;
                    e.o.rd0 = 3'(cnt);
                    e.o.rd1 = 3'(cnt);
                    if (s == 3)      e.o.rd2 = 3'(stage3_rd2[cnt]);
                    else if (s >= 2) e.o.rd2 = 3'(cnt ^ (1 << (s - 2)));
                    else             e.o.rd2 = 3'(cnt);
                    e.o.rd3 = e.o.rd2;
                    e.o.rom = (s >= 2) ? 3'(cnt << (4 - s)) : 3'd0;
                end
                if (j >= 5 && (j % 2) == 1) begin
                    wr         = (j - 5) / 2;
                    e.o.we     = 1'b1;
                    e.o.wr     = 3'(wr);
                    e.o.subsec = (s >= 2) ? 1'((wr >> (s - 2)) & 1) : 1'b0;
                end
                exp_q.push_back(e);
            end
        end
        done_q.push_back(c0 + 1 + STAGES * STAGE_CYC);
    endtask

    task automatic issue_start(output int c0);
        start  = 1'b1;
        c0     = cyc;
        we_cnt = 0;
        push_run(c0);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done within budget", done_q.size(), 0);
    endtask

    initial begin : monitor
        obs_t o;
        obs_t d;
        exp_t e;
        int   dc;
        forever begin
            @(negedge clk);
            o = sample();
            if (o.busy) begin
                if (prev_sec >= 0 && int'(o.sector) != prev_sec)
                    chk("next stage after last write", 32'(cyc > last_we_cyc), 1);
                prev_sec = int'(o.sector);
                if (exp_q.size() == 0) begin
                    chk("busy without pending work", 32'(o.busy), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("busy cycle", cyc, e.cyc);
                    chk("outputs", 32'(o), 32'(e.o));
                end
            end else begin
                prev_sec = -1;
                if (o.done) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected done", 32'(o.done), 0);
                    end else begin
                        dc = done_q.pop_front();
                        chk("done cycle", cyc, dc);
                        d      = '0;
                        d.done = 1'b1;
                        chk("done outputs", 32'(o), 32'(d));
                    end
                end else begin
                    chk("idle outputs", 32'(o), 0);
                end
            end
            if (o.we) begin
                we_cnt++;
                last_we_cyc = cyc;
            end
        end
    end

    initial begin : stim
        int c0;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full transform with a stray start pulse during stage 2 READ.
        issue_start(c0);
        wait_cyc(c0 + 45);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(200);
        chk("run A drained", exp_q.size(), 0);
        chk("run A write pulses", we_cnt, 40);

        // Abort during stage 1 DRAIN.
        repeat (3) @(posedge clk);
        #1;
        issue_start(c0);
        wait_cyc(c0 + 39);
        rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("writes before abort", we_cnt, 15);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no writes after abort", we_cnt, 15);

        // Fresh transform after the abort.
        issue_start(c0);
        wait_done(200);
        chk("run C drained", exp_q.size(), 0);
        chk("run C write pulses", we_cnt, 40);
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/fht_stage_ctrl.md
FHT_STAGE_CTRL -- requirements
Module: fht_stage_ctrl

Interface
REQ-001 SHALL have parameters: A_BIT, default 8, bank address width (bank depth 2^A_BIT, N = 4*2^A_BIT points).
REQ-002 SHALL have parameters: SEC_BIT, default 4, sector/stage index width.
REQ-003 SHALL have parameters: PIPE_LAT, default 4, cycles from a phase-1 read address to the butterfly-block output being valid.
REQ-004 SHALL have ports:
- iCLK  in  1  clock.
- iRESET  in  1  reset, asynchronous, active-low.
- iSTART  in  1  start request, single-cycle pulse.
- oBUSY  out  1  transform in progress.
- oDONE  out  1  one-cycle completion pulse.
- oRD_ADDR_0..oRD_ADDR_3  out  A_BIT each  read addresses, banks 0-3.
- oROM_ADDR  out  A_BIT  twiddle ROM address.
- oWR_ADDR  out  A_BIT  write-back address.
- oWE  out  1  write-back strobe.
- oST_ZERO  out  1  stage 0 active.
- oST_LAST  out  1  last stage active.
- o2ND_PART_SUBSEC  out  1  output-mixer swap select.
- oSECTOR  out  SEC_BIT  current stage index.

Function
REQ-005 SHALL define LAST = A_BIT+1; stage index s counts 0..LAST.
REQ-006 SHALL implement FSM states IDLE, READ, DRAIN, DONE; reset state IDLE.
REQ-007 IDLE -> READ on iSTART=1, with s=0, cnt=0, phase=0.
REQ-008 iSTART SHALL be ignored in every state other than IDLE.
REQ-009 In READ, phase SHALL toggle every cycle; cnt (A_BIT bits) SHALL increment when phase=1.
REQ-010 READ -> DRAIN when cnt = 2^A_BIT-1 and phase=1.
REQ-011 DRAIN SHALL last exactly PIPE_LAT cycles.
REQ-012 At DRAIN end: if s<LAST, s increments, cnt and phase clear, and the FSM goes to READ; if s=LAST, the FSM goes to DONE.
REQ-013 DONE SHALL last one cycle with oDONE=1, then go to IDLE.
REQ-014 Read addresses:
- oRD_ADDR_0 = oRD_ADDR_1 = cnt.
- oRD_ADDR_2 = oRD_ADDR_3 = cnt XOR (1 << (s-2)) for s>=2, else cnt.
- All four SHALL be valid in READ and 0 elsewhere.
REQ-015 oROM_ADDR = (cnt << (A_BIT+1-s)) truncated to A_BIT bits for s>=2, else 0.
REQ-016 oWE SHALL pulse exactly PIPE_LAT cycles after each phase-1 READ cycle; oWR_ADDR SHALL equal that cycle's cnt, delayed by a PIPE_LAT-deep shift register.
REQ-017 Each stage SHALL produce exactly 2^A_BIT oWE pulses, the last in the final DRAIN cycle; no read of stage s+1 SHALL precede the last write of stage s.
REQ-018 Stage flags:
- oST_ZERO = (s=0) in READ/DRAIN.
- oST_LAST = (s=LAST) in READ/DRAIN.
- oSECTOR = s, zero-extended, in READ/DRAIN.
- All three SHALL be 0 in IDLE/DONE.
REQ-019 o2ND_PART_SUBSEC = bit (s-2) of the delayed write address for s>=2, else 0; it SHALL be aligned with oWE.
REQ-020 oBUSY SHALL be 1 in READ and DRAIN, 0 in IDLE and DONE.
REQ-021 Total time from the iSTART cycle to oDONE SHALL be (LAST+1)*(2^(A_BIT+1)+PIPE_LAT)+1 cycles.

Reset
REQ-022 On iRESET=0, the FSM SHALL go to IDLE; s, cnt, phase and the delay line SHALL clear; all outputs SHALL be 0.
REQ-023 Reset mid-transform SHALL abort with no further oWE pulses and no oDONE pulse.
REQ-024 The first iSTART after reset release SHALL start a complete fresh transform.

Structure
REQ-025 FSM state encodings and LAST derivation SHALL live in the shared FHT package; A_BIT, SEC_BIT and PIPE_LAT SHALL be parameters.
REQ-026 The PIPE_LAT write-address/strobe delay line SHALL be the single sub-module fht_delay_line, parameterised by width and depth.

Verification
REQ-027 Bench SHALL use A_BIT=3, PIPE_LAT=4 and cover:
- Reset, then iSTART -> oDONE exactly 101 cycles after start; oBUSY high for 100 cycles.
- Stage 0 -> 8 oWE pulses, oWR_ADDR 0..7, first oWE 5 cycles after the first READ cycle; oST_ZERO=1 throughout the stage.
- Stage 3 -> oRD_ADDR_2 sequence 2,3,0,1,6,7,4,5; oROM_ADDR = cnt<<1 mod 8; o2ND_PART_SUBSEC = wr_addr bit 1.
- iSTART pulsed during READ of stage 2 -> ignored; timing unchanged; single oDONE.
- iRESET low during DRAIN of stage 1 -> all outputs 0 next cycle, no oDONE; a later iSTART completes in 101 cycles.
- Every stage -> no READ cycle precedes the prior stage's final oWE; 40 total oWE pulses.
